motor_dir_sequencer: RTL and testbench

MOTOR_DIR_SEQUENCER -- requirements
Module: motor_dir_sequencer

---
 rtl/motor_ctrl_pkg.sv | 33 +++
 rtl/ramp_tick_gen.sv | 26 ++
 rtl/motor_dir_sequencer.sv | 151 +++++++++++++++
 tb/tb_motor_dir_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the motor direction sequencer:
// FSM state encoding, duty width and duty arithmetic.
package motor_ctrl_pkg;

  localparam int DUTY_W = 7;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t DUTY_MAX = 7'd100;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BRAKE = 2'd1,
    ST_DEAD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  function automatic duty_t clamp_duty(input duty_t d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  // Move cur toward tgt by at most step; the result always lies between cur and tgt.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt, input duty_t step);
    duty_t diff;
    if (cur < tgt) begin
      diff = tgt - cur;
      return cur + ((diff < step) ? diff : step);
    end
    diff = cur - tgt;
    return cur - ((diff < step) ? diff : step);
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every RAMP_DIV clocks.
module ramp_tick_gen #(
  parameter int RAMP_DIV = 100000
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic tick
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/motor_dir_sequencer.sv
// Duty/direction sequencer for an H-bridge: ramps duty, brakes to zero and waits
// a dead time before reversing, and latches a stall fault from encoder windows.
module motor_dir_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int RAMP_DIV      = 100000,
  parameter int STEP          = 1,
  parameter int DEAD_CYCLES   = 1000000,
  parameter int STALL_DUTY    = 20,
  parameter int STALL_WINDOWS = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_dir,
  input  logic [31:0]       pulse_count,
  input  logic              pulse_update,
  input  logic              fault_clear,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              Dir,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        state
);

  localparam int DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int STALL_W = $clog2(STALL_WINDOWS + 1);
  localparam logic [DEAD_W-1:0]  DEAD_LOAD  = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_WINDOWS - 1);
  localparam duty_t STEP_D    = duty_t'(STEP);
  localparam duty_t STALL_MIN = duty_t'(STALL_DUTY);

  state_t              state_q, state_d;
  duty_t               duty_q, duty_d;
  duty_t               tgt_duty_q, tgt_duty_d;
  logic                dir_q, dir_d;
  logic                tgt_dir_q, tgt_dir_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                fault_q, fault_d;
  logic                tick;
  logic                stall_window;

  ramp_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    tgt_duty_d = tgt_duty_q;
    dir_d      = dir_q;
    tgt_dir_d  = tgt_dir_q;
    dead_d     = dead_q;
    stall_d    = stall_q;
    fault_d    = fault_q;

    stall_window = pulse_update && (duty_q >= STALL_MIN) && (pulse_count == 32'd0);

    case (state_q)
      ST_RUN: begin
        if (cmd_valid) begin
          tgt_duty_d = clamp_duty(cmd_duty);
          tgt_dir_d  = cmd_dir;
        end
        if (pulse_update) stall_d = stall_window ? stall_q + STALL_W'(1) : '0;

        // A stall outranks both reversal and ramping in the same cycle.
        if (stall_window && (stall_q == STALL_LAST)) begin
          state_d = ST_FAULT;
          duty_d  = '0;
          fault_d = 1'b1;
          stall_d = '0;
        end else if (tgt_dir_q != dir_q) begin
          stall_d = '0;
          if (duty_q != '0) begin
            state_d = ST_BRAKE;
          end else begin
            state_d = ST_DEAD;
            dead_d  = DEAD_LOAD;
          end
        end else if (tick) begin
          duty_d = step_toward(duty_q, tgt_duty_q, STEP_D);
        end
      end

      ST_BRAKE: begin
        if (duty_q == '0) begin
          state_d = ST_DEAD;
          dead_d  = DEAD_LOAD;
        end else if (tick) begin
          duty_d = step_toward(duty_q, '0, STEP_D);
        end
      end

      ST_DEAD: begin
        if (dead_q == '0) begin
          state_d = ST_RUN;
          dir_d   = tgt_dir_q;
        end else begin
          dead_d = dead_q - DEAD_W'(1);
        end
      end

      ST_FAULT: begin
        if (fault_clear) begin
          state_d    = ST_RUN;
          fault_d    = 1'b0;
          tgt_duty_d = '0;
          tgt_dir_d  = dir_q;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_RUN;
      duty_q     <= '0;
      tgt_duty_q <= '0;
      dir_q      <= 1'b0;
      tgt_dir_q  <= 1'b0;
      dead_q     <= '0;
      stall_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      tgt_duty_q <= tgt_duty_d;
      dir_q      <= dir_d;
      tgt_dir_q  <= tgt_dir_d;
      dead_q     <= dead_d;
      stall_q    <= stall_d;
      fault_q    <= fault_d;
    end
  end

  assign cmd_ready  = (state_q == ST_RUN);
  assign duty_cycle = duty_q;
  assign Dir        = dir_q;
  assign fault      = fault_q;
  assign state      = state_q;
  assign busy       = (state_q != ST_RUN) || (duty_q != tgt_duty_q) || (dir_q != tgt_dir_q);

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// Directed bench for motor_dir_sequencer: a table of command vectors with expected
// duty trajectories, plus hand sequences for dead time, reset, clamp and stall faults.
module tb_motor_dir_sequencer;

  localparam int RAMP_DIV      = 4;
  localparam int STEP          = 5;
  localparam int DEAD_CYCLES   = 8;
  localparam int STALL_DUTY    = 20;
  localparam int STALL_WINDOWS = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_duty = '0;
  logic        cmd_dir = 1'b0;
  logic [31:0] pulse_count = '0;
  logic        pulse_update = 1'b0;
  logic        fault_clear = 1'b0;
  logic [6:0]  duty_cycle;
  logic        Dir;
  logic        busy;
  logic        fault;
  logic [1:0]  state;

  always #5 Clk = ~Clk;

  motor_dir_sequencer #(
    .RAMP_DIV      (RAMP_DIV),
    .STEP          (STEP),
    .DEAD_CYCLES   (DEAD_CYCLES),
    .STALL_DUTY    (STALL_DUTY),
    .STALL_WINDOWS (STALL_WINDOWS)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_duty     (cmd_duty),
    .cmd_dir      (cmd_dir),
    .pulse_count  (pulse_count),
    .pulse_update (pulse_update),
    .fault_clear  (fault_clear),
    .duty_cycle   (duty_cycle),
    .Dir          (Dir),
    .busy         (busy),
    .fault        (fault),
    .state        (state)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [6:0]      cmd_duty;
    logic            cmd_dir;
    logic [3:0]      n;
    logic [7:0][6:0] seq;
    logic            fin_dir;
    logic            busy_end;
    logic            gap_chk;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_cmd(input logic [6:0] d, input logic dr);
    int i;
    i = 0;
    while (!cmd_ready && i < 200) begin
      step();
      i++;
    end
    check("cmd_ready_before_send", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_duty  = d;
    cmd_dir   = dr;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int i;
    i = 0;
    while (busy && i < max) begin
      step();
      i++;
    end
    check(name, busy, 0);
  endtask

  task automatic strobe(input logic [31:0] c);
    pulse_count  = c;
    pulse_update = 1'b1;
    step();
    pulse_update = 1'b0;
    step();
    step();
  endtask

  task automatic clear_fault();
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          last_cyc;
    int          w;
    int          n;
    logic [6:0]  prev;

    for (int i = 0; i < 5; i++) vecs[i] = '0;
    vecs[0].cmd_duty = 7'd23; vecs[0].cmd_dir = 1'b0; vecs[0].n = 4'd5; vecs[0].fin_dir = 1'b0;
    vecs[0].gap_chk = 1'b1;
    vecs[0].seq[0] = 7'd5;  vecs[0].seq[1] = 7'd10; vecs[0].seq[2] = 7'd15;
    vecs[0].seq[3] = 7'd20; vecs[0].seq[4] = 7'd23;
    vecs[1].cmd_duty = 7'd10; vecs[1].cmd_dir = 1'b1; vecs[1].n = 4'd7; vecs[1].fin_dir = 1'b1;
    vecs[1].seq[0] = 7'd18; vecs[1].seq[1] = 7'd13; vecs[1].seq[2] = 7'd8;
    vecs[1].seq[3] = 7'd3;  vecs[1].seq[4] = 7'd0;  vecs[1].seq[5] = 7'd5; vecs[1].seq[6] = 7'd10;
    vecs[2].cmd_duty = 7'd0; vecs[2].cmd_dir = 1'b1; vecs[2].n = 4'd2; vecs[2].fin_dir = 1'b1;
    vecs[2].seq[0] = 7'd5; vecs[2].seq[1] = 7'd0;
    vecs[3].cmd_duty = 7'd3; vecs[3].cmd_dir = 1'b1; vecs[3].n = 4'd1; vecs[3].fin_dir = 1'b1;
    vecs[3].seq[0] = 7'd3;
    vecs[4].cmd_duty = 7'd0; vecs[4].cmd_dir = 1'b0; vecs[4].n = 4'd1; vecs[4].fin_dir = 1'b0;
    vecs[4].busy_end = 1'b1;
    vecs[4].seq[0] = 7'd0;

    // Reset values
    step();
    step();
    check("rst_state", state, 0);
    check("rst_duty", duty_cycle, 0);
    check("rst_dir", Dir, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_fault", fault, 0);
    Reset_n = 1'b1;
    step();

    // Table-driven command vectors
    for (int v = 0; v < 5; v++) begin
      send_cmd(vecs[v].cmd_duty, vecs[v].cmd_dir);
      last_cyc = cyc;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        prev = duty_cycle;
        w = 0;
        while (duty_cycle == prev && w < 300) begin
          step();
          w++;
        end
        check($sformatf("v%0d_duty%0d", v, k), duty_cycle, vecs[v].seq[k]);
        if (k == int'(vecs[v].n) - 1)
          check($sformatf("v%0d_busy%0d", v, k), busy, vecs[v].busy_end);
        else
          check($sformatf("v%0d_busy%0d", v, k), busy, 1);
        if (vecs[v].gap_chk && k > 0)
          check($sformatf("v%0d_gap%0d", v, k), cyc - last_cyc, RAMP_DIV);
        last_cyc = cyc;
      end
      wait_idle($sformatf("v%0d_idle", v), 300);
      check($sformatf("v%0d_dir", v), Dir, vecs[v].fin_dir);
      check($sformatf("v%0d_state", v), state, 0);
      check($sformatf("v%0d_final_duty", v), duty_cycle, vecs[v].seq[int'(vecs[v].n) - 1]);
    end

    // Reset asserted mid-DEAD (Dir=0, target_dir=1)
    send_cmd(7'd0, 1'b1);
    w = 0;
    while (state != 2'd2 && w < 20) begin
      step();
      w++;
    end
    check("rstdead_entered", state, 2);
    step();
    step();
    #2 Reset_n = 1'b0;
    #1;
    check("rstdead_state", state, 0);
    check("rstdead_duty", duty_cycle, 0);
    check("rstdead_dir", Dir, 0);
    check("rstdead_busy", busy, 0);
    check("rstdead_ready", cmd_ready, 1);
    check("rstdead_fault", fault, 0);
    step();
    step();
    Reset_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("rstdead_dir_after", Dir, 0);
    check("rstdead_state_after", state, 0);
    check("rstdead_busy_after", busy, 0);

    // Dead time length straight from RUN at duty 0
    send_cmd(7'd0, 1'b1);
    w = 0;
    while (state != 2'd2 && w < 20) begin
      step();
      w++;
    end
    check("dead_dir_before", Dir, 0);
    n = 0;
    while (state == 2'd2 && n < 100) begin
      step();
      n++;
    end
    check("dead_len", n, DEAD_CYCLES);
    check("dead_dir_after", Dir, 1);
    check("dead_state_after", state, 0);

    // Target clamp and saturation
    send_cmd(7'd120, 1'b1);
    wait_idle("clamp_idle", 1000);
    check("clamp_duty", duty_cycle, 100);
    for (int i = 0; i < 10; i++) step();
    check("clamp_hold", duty_cycle, 100);
    check("clamp_busy", busy, 0);

    // Stall fault at duty 30
    send_cmd(7'd30, 1'b1);
    wait_idle("fault_idle", 1000);
    check("fault_duty30", duty_cycle, 30);
    strobe(32'd0);
    check("fault_one_window", state, 0);
    pulse_count  = 32'd0;
    pulse_update = 1'b1;
    step();
    pulse_update = 1'b0;
    check("fault_state", state, 3);
    check("fault_duty0", duty_cycle, 0);
    check("fault_flag", fault, 1);
    check("fault_dir_held", Dir, 1);
    cmd_valid = 1'b1;
    cmd_duty  = 7'd50;
    cmd_dir   = 1'b0;
    step();
    check("fault_ready", cmd_ready, 0);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("fault_duty_hold", duty_cycle, 0);
    check("fault_state_hold", state, 3);
    clear_fault();
    check("clear_state", state, 0);
    check("clear_fault", fault, 0);
    check("clear_duty", duty_cycle, 0);
    for (int i = 0; i < 8; i++) step();
    check("clear_duty_later", duty_cycle, 0);
    check("clear_busy", busy, 0);
    check("clear_dir", Dir, 1);

    // Nonzero window clears the stall counter
    send_cmd(7'd30, 1'b1);
    wait_idle("nofault_idle", 1000);
    strobe(32'd0);
    strobe(32'd7);
    strobe(32'd0);
    check("nofault_state", state, 0);
    check("nofault_flag", fault, 0);
    check("nofault_duty", duty_cycle, 30);
    strobe(32'd0);
    check("refault_state", state, 3);
    clear_fault();

    // Stall threshold boundary: below STALL_DUTY ignored, at STALL_DUTY counted
    send_cmd(7'd15, 1'b1);
    wait_idle("below_idle", 1000);
    strobe(32'd0);
    strobe(32'd0);
    check("below_thresh_state", state, 0);
    send_cmd(7'd20, 1'b1);
    wait_idle("at_idle", 1000);
    strobe(32'd0);
    strobe(32'd0);
    check("at_thresh_state", state, 3);
    check("at_thresh_fault", fault, 1);
    clear_fault();
    check("at_thresh_clear", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
